// File: rtl/svi_chan_pkg.sv
// Shared definitions for the multi-channel FIFO: default parameters,
// occupancy-width function and packed channel-slice helper.
package svi_chan_pkg;

   localparam int DEF_WIDTH          = 8;
   localparam int DEF_DEPTH          = 4;
   localparam int DEF_NUM_CH         = 2;
   localparam int DEF_CLR_ON_DISABLE = 0;

   // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // LSB of channel ch inside a packed NUM_CH*width bus.
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/svi_chan_fifo_ch.sv
// Single FIFO channel: flop storage, wrapping pointers, occupancy count and
// sticky overflow flag.
module svi_chan_fifo_ch
   import svi_chan_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int CLR_ON_DISABLE = DEF_CLR_ON_DISABLE
) (
   input  logic                      i_clk,
   input  logic                      i_arst,
   input  logic                      en,
   input  logic                      wr_valid,
   input  logic [WIDTH-1:0]          wr_data,
   output logic                      wr_ready,
   output logic                      rd_valid,
   output logic [WIDTH-1:0]          rd_data,
   input  logic                      rd_ready,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             push;
   logic             pop;
   logic             drop;

   // Handshake: a transfer happens on a rising edge when en is high and both
   // valid and ready are high; ready/valid come from the registered count only.
   assign wr_ready = (cnt < CW'(DEPTH));
   assign rd_valid = (cnt != '0);
   assign push     = en & wr_valid & wr_ready;
   assign pop      = en & rd_valid & rd_ready;
   assign drop     = en & wr_valid & ~wr_ready;

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else if (en) begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (drop) ovf_q <= 1'b1;
      end else if (CLR_ON_DISABLE != 0) begin
         // Flush while disabled; the sticky overflow flag survives.
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end
   end

   // Storage is deliberately not reset; only an accepted push writes it.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign count   = cnt;
   assign ovf     = ovf_q;

endmodule

// File: rtl/svi_chan_fifo.sv
// NUM_CH independent FIFO channels sharing one clock, reset and enable,
// with all per-channel data packed onto flat buses.
module svi_chan_fifo
   import svi_chan_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int CLR_ON_DISABLE = DEF_CLR_ON_DISABLE
) (
   input  logic                             i_clk,
   input  logic                             i_arst,
   input  logic                             en,
   input  logic [NUM_CH-1:0]                i_valid,
   input  logic [NUM_CH*WIDTH-1:0]          i_data,
   output logic [NUM_CH-1:0]                o_ready,
   output logic [NUM_CH-1:0]                o_valid,
   output logic [NUM_CH*WIDTH-1:0]          o_data,
   input  logic [NUM_CH-1:0]                i_ready,
   output logic [NUM_CH*cnt_w(DEPTH)-1:0]   o_count,
   output logic [NUM_CH-1:0]                o_ovf
);

   localparam int CW = cnt_w(DEPTH);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      svi_chan_fifo_ch #(
         .WIDTH          (WIDTH),
         .DEPTH          (DEPTH),
         .CLR_ON_DISABLE (CLR_ON_DISABLE)
      ) u_ch (
         .i_clk    (i_clk),
         .i_arst   (i_arst),
         .en       (en),
         .wr_valid (i_valid[c]),
         .wr_data  (i_data[ch_lsb(c, WIDTH) +: WIDTH]),
         .wr_ready (o_ready[c]),
         .rd_valid (o_valid[c]),
         .rd_data  (o_data[ch_lsb(c, WIDTH) +: WIDTH]),
         .rd_ready (i_ready[c]),
         .count    (o_count[ch_lsb(c, CW) +: CW]),
         .ovf      (o_ovf[c])
      );
   end

endmodule
